// File: rtl/dot_sequencer.sv
// Streams a/b pairs into an external fused multiply-add unit and collects the accumulated dot product.
// The fma owns all arithmetic; this block only sequences its control pins and captures the result.
module dot_sequencer #(
  parameter int WIDTH       = 16,
  parameter int FIXED_POINT = 10,
  parameter int LEN_BITS    = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [LEN_BITS-1:0]  len_in,
  input  logic [WIDTH-1:0]     bias_in,
  input  logic                 elem_valid_in,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 elem_ready_out,
  output logic [3*WIDTH-1:0]   fma_abc_out,
  output logic                 fma_valid_out,
  output logic                 fma_c_valid_out,
  output logic                 fma_output_can_be_valid_out,
  input  logic [WIDTH-1:0]     fma_out_in,
  input  logic                 fma_valid_in,
  output logic [WIDTH-1:0]     result_out,
  output logic                 result_valid_out,
  input  logic                 result_ready_in,
  output logic                 busy_out
);

  if (FIXED_POINT >= WIDTH) begin : g_fp_check
    $error("FIXED_POINT must be smaller than WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [LEN_BITS-1:0]  r_remaining;
  logic [WIDTH-1:0]     r_bias;
  logic [WIDTH-1:0]     r_result;
  logic                 r_first;
  logic                 w_xfer;
  logic                 w_last;

  assign elem_ready_out   = (r_state == S_RUN);
  assign w_xfer           = elem_ready_out & elem_valid_in;
  assign w_last           = (r_remaining == LEN_BITS'(1));
  assign busy_out         = (r_state != S_IDLE);
  assign result_valid_out = (r_state == S_DONE);
  assign result_out       = r_result;

  // Idle keeps every combinational output quiet, including the operand bus.
  assign fma_abc_out                 = busy_out ? {a_in, b_in, r_bias} : '0;
  assign fma_valid_out               = w_xfer;
  assign fma_c_valid_out             = w_xfer & r_first;
  assign fma_output_can_be_valid_out = w_xfer & w_last;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_in) w_next = (len_in != '0) ? S_RUN : S_DONE;
      S_RUN:  if (w_xfer && w_last) w_next = S_WAIT;
      S_WAIT: if (fma_valid_in) w_next = S_DONE;
      S_DONE: if (result_ready_in) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_bias      <= '0;
      r_first     <= 1'b0;
      r_result    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start_in) begin
          // A zero-length job is just the bias; the fma is never touched.
          if (len_in != '0) begin
            r_remaining <= len_in;
            r_bias      <= bias_in;
            r_first     <= 1'b1;
          end else begin
            r_result <= bias_in;
          end
        end
        S_RUN: if (w_xfer) begin
          r_remaining <= r_remaining - LEN_BITS'(1);
          r_first     <= 1'b0;
        end
        S_WAIT: if (fma_valid_in) r_result <= fma_out_in;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dot_sequencer.md
DOT_SEQUENCER -- requirements
Module: dot_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the bit width of each fixed-point operand and result.
REQ-002 Parameter FIXED_POINT, default 10, SHALL set the fractional bits; it is informational only, since the attached fma performs the scaling.
REQ-003 Parameter LEN_BITS, default 8, SHALL set the width of the vector-length field (maximum length 2^LEN_BITS-1).
REQ-004 Ports SHALL be as follows; the block uses one clock, and reset is synchronous and active-high:
 clk_in  in  1  clock
 rst_in  in  1  synchronous active-high reset
 start_in  in  1  begin a dot product (accepted only in IDLE)
 len_in  in  LEN_BITS  number of element pairs
 bias_in  in  WIDTH  initial accumulator value c
 elem_valid_in  in  1  a_in/b_in pair valid
 a_in, b_in  in  WIDTH each  signed operands
 elem_ready_out  out  1  pair accepted this cycle when high with elem_valid_in
 fma_abc_out  out  3*WIDTH  {a,b,c} to fma abc
 fma_valid_out  out  1  to fma valid_in
 fma_c_valid_out  out  1  to fma c_valid_in
 fma_output_can_be_valid_out  out  1  to fma output_can_be_valid_in
 fma_out_in  in  WIDTH  from fma out
 fma_valid_in  in  1  from fma valid_out
 result_out  out  WIDTH  dot product + bias
 result_valid_out  out  1  result held valid until accepted
 result_ready_in  in  1  consumer accepts result
 busy_out  out  1  high whenever state is not IDLE

Function
REQ-005 The FSM SHALL have four states: IDLE, RUN, WAIT and DONE.
REQ-006 In IDLE, when start_in=1 and len_in!=0, the block SHALL latch len_in into a remaining counter and bias_in into a bias register, set the first flag, and go to RUN.
REQ-007 In IDLE, when start_in=1 and len_in=0, the block SHALL load result_out with bias_in and go to DONE; no fma activity occurs.
REQ-008 start_in SHALL be ignored in RUN, WAIT and DONE.
REQ-009 elem_ready_out SHALL be 1 only in RUN (combinational from state); a transfer occurs when elem_valid_in=1 and elem_ready_out=1.
REQ-010 fma_valid_out SHALL equal the transfer condition, and fma_abc_out SHALL equal {a_in, b_in, bias register} combinationally.
REQ-011 fma_c_valid_out SHALL be 1 only on the first transfer of a job, so that the fma accumulator starts from the bias.
REQ-012 fma_output_can_be_valid_out SHALL be 1 only on the transfer when remaining=1 (the last element).
REQ-013 Each transfer SHALL decrement remaining by 1 and clear first; the transfer at remaining=1 SHALL move the FSM to WAIT.
REQ-014 A RUN cycle with elem_valid_in=0 SHALL drive all fma control outputs to 0, so the fma holds its accumulator and the counter is unchanged.
REQ-015 In WAIT, when fma_valid_in=1 the block SHALL register fma_out_in into result_out and go to DONE; fma_valid_in outside WAIT SHALL be ignored.
REQ-016 In DONE, result_valid_out SHALL be 1 and result_out SHALL be stable; when result_ready_in=1 the block SHALL go to IDLE the next cycle.
REQ-017 Latency: with the last transfer at cycle T, result_valid_out SHALL first be high at cycle T+2, given a 1-cycle fma.
REQ-018 len_in=1 SHALL assert fma_c_valid_out and fma_output_can_be_valid_out on the same transfer.
REQ-019 The block performs no arithmetic; all wrap/overflow behaviour is the fma's two's-complement WIDTH-bit wrap.

Reset
REQ-020 When rst_in=1 at a clock edge, the block SHALL enter IDLE and clear remaining, bias, first, result_out and result_valid_out to 0.
REQ-021 A reset mid-job SHALL abandon the job with no result produced; the fma SHALL share rst_in.
REQ-022 Combinational outputs SHALL be 0 in IDLE.

Verification
The bench instantiates fma (WIDTH=16, FIXED_POINT=10) wired to the fma ports; Q6.10 encoding, 1.0=0x0400.
REQ-023 Test: len=3, bias=0x0400, pairs (0x0800,0x0400), (0x0400,0x0400), (0xFC00,0x0800) streamed back-to-back -> result_out=0x0800 (2.0) at T+2, and c_valid only on pair 1.
REQ-024 Test: same job with elem_valid_in low for 2 cycles between pairs -> same 0x0800 result, and fma_valid_out low during the gaps.
REQ-025 Test: len=0, bias=0x1234 -> DONE one cycle after start with result_out=0x1234 and fma_valid_out never high.
REQ-026 Test: len=1, bias=0, pair (0x0C00,0x0800) -> result_out=0x1800 (6.0), with c_valid and output_can_be_valid both high on the single transfer.
REQ-027 Test: result_ready_in held low 5 cycles -> result_valid_out and result_out stable; start_in pulses in DONE ignored; IDLE one cycle after ready.
REQ-028 Test: rst_in asserted after 2 of 4 transfers -> IDLE and outputs 0 next cycle; a new len=2 job then produces the correct result.
